dp_sequencer: RTL and testbench

Multi-cycle controller that sequences the 16x32 register-file/ALU datapath. It accepts packed 3-operand instructions over a valid/ready handshake, decodes them onto the datapath's `rs`/`rt`/`rd`/`alu_control` inputs, and pulses `wrReg` for exactly one cycle. It returns each ALU result over a valid/ready response channel and keeps a retired-instruction counter. It sits between an instruction source (bench, loader or host FSM) and `datapath`.

---
 rtl/dp_seq_pkg.sv | 36 +++
 rtl/dp_seq_decode.sv | 20 ++
 rtl/dp_sequencer.sv | 142 ++++++++++++++
 tb/tb_dp_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_seq_pkg.sv
// dp_seq_pkg: shared types and constants for the datapath sequencer.
package dp_seq_pkg;

  // Controller phases; one instruction is in flight at a time.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // ALU opcodes understood by the datapath.
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;

  // Highest opcode with a defined ALU operation.
  localparam int OP_LEGAL_MAX = 7;

  // Instruction word layout: {op, rd, rs, rt}.
  localparam int INSTR_W = 16;
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;

endpackage

// File: rtl/dp_seq_decode.sv
// dp_seq_decode: splits an instruction word into its fields and flags
// opcodes outside the defined ALU set.
module dp_seq_decode
  import dp_seq_pkg::*;
(
  input  logic [INSTR_W-1:0]       instr_i,
  output logic [OP_MSB-OP_LSB:0]   op_o,
  output logic [RD_MSB-RD_LSB:0]   rd_o,
  output logic [RS_MSB-RS_LSB:0]   rs_o,
  output logic [RT_MSB-RT_LSB:0]   rt_o,
  output logic                     illegal_o
);

  assign op_o      = instr_i[OP_MSB:OP_LSB];
  assign rd_o      = instr_i[RD_MSB:RD_LSB];
  assign rs_o      = instr_i[RS_MSB:RS_LSB];
  assign rt_o      = instr_i[RT_MSB:RT_LSB];
  assign illegal_o = (int'(op_o) > OP_LEGAL_MAX);

endmodule

// File: rtl/dp_sequencer.sv
// dp_sequencer: multi-cycle controller for the register-file/ALU datapath.
// IDLE -> DECODE -> EXEC -> RESP, one instruction in flight.
// Build option: define DP_SEQ_ILLEGAL_TRAP_EN to trap opcodes 0x8-0xF
// (no register write, error response) instead of executing them.
module dp_sequencer
  import dp_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  input  logic [OP_W+3*REG_AW-1:0] instr,
  output logic                     instr_ready,
  output logic [REG_AW-1:0]        dp_rs,
  output logic [REG_AW-1:0]        dp_rt,
  output logic [REG_AW-1:0]        dp_rd,
  output logic [OP_W-1:0]          dp_alu_control,
  output logic                     dp_wrReg,
  input  logic [DATA_W-1:0]        dp_out_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_W-1:0]        resp_data,
  output logic [REG_AW-1:0]        resp_rd,
  output logic                     resp_err,
  output logic                     busy,
  output logic [CNT_W-1:0]         instr_count
);

`ifdef DP_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_e              state_q;
  logic [REG_AW-1:0]   dp_rs_q, dp_rt_q, dp_rd_q;
  logic [OP_W-1:0]     dp_op_q;
  logic                wr_q;
  logic                trap_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic [REG_AW-1:0]   resp_rd_q;
  logic                resp_err_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [OP_W-1:0]     dec_op;
  logic [REG_AW-1:0]   dec_rd, dec_rs, dec_rt;
  logic                dec_illegal;
  logic                trap;

  // Decode straight off the input so fields are latched at the accept edge.
  dp_seq_decode u_decode (
    .instr_i   (instr),
    .op_o      (dec_op),
    .rd_o      (dec_rd),
    .rs_o      (dec_rs),
    .rt_o      (dec_rt),
    .illegal_o (dec_illegal)
  );

  assign trap  = dec_illegal && TRAP_EN;
  assign cnt_d = cnt_q + CNT_W'(1);

  // Sequencer FSM with registered datapath controls, response and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dp_rs_q      <= '0;
      dp_rt_q      <= '0;
      dp_rd_q      <= '0;
      dp_op_q      <= '0;
      wr_q         <= 1'b0;
      trap_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      resp_err_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            dp_rs_q <= dec_rs;
            dp_rt_q <= dec_rt;
            dp_rd_q <= dec_rd;
            dp_op_q <= dec_op;
            trap_q  <= trap;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (trap_q) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= '0;
            resp_rd_q    <= dp_rd_q;
            resp_err_q   <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            wr_q    <= 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Captured on the write edge, so the result uses pre-write operands.
          wr_q         <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_data_q  <= dp_out_data;
          resp_rd_q    <= dp_rd_q;
          resp_err_q   <= 1'b0;
          cnt_q        <= cnt_d;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Reset gates the handshake/write outputs so nothing leaks while it is held.
  assign instr_ready    = (state_q == S_IDLE) && !reset;
  assign dp_wrReg       = wr_q && !reset;
  assign dp_rs          = dp_rs_q;
  assign dp_rt          = dp_rt_q;
  assign dp_rd          = dp_rd_q;
  assign dp_alu_control = dp_op_q;
  assign resp_valid     = resp_valid_q;
  assign resp_data      = resp_data_q;
  assign resp_rd        = resp_rd_q;
  assign resp_err       = resp_err_q;
  assign busy           = (state_q != S_IDLE);
  assign instr_count    = cnt_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer: directed + randomized bench with a scoreboard queue.
// A small register-file/ALU model stands in for the datapath (Rn=n at reset).
module tb_dp_sequencer;

`ifdef DP_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [3:0]  dp_rs, dp_rt, dp_rd, dp_alu_control;
  logic        dp_wrReg;
  logic [31:0] dp_out_data;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic [3:0]  resp_rd;
  logic        resp_err;
  logic        busy;
  logic [15:0] instr_count;

  always #5 clk = ~clk;

  dp_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .dp_rs(dp_rs), .dp_rt(dp_rt), .dp_rd(dp_rd),
    .dp_alu_control(dp_alu_control), .dp_wrReg(dp_wrReg),
    .dp_out_data(dp_out_data), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_rd(resp_rd),
    .resp_err(resp_err), .busy(busy), .instr_count(instr_count)
  );

  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Datapath stand-in: combinational read/ALU, write on wrReg, R0 hardwired 0.
  logic [31:0] rf [16];
  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 16; i++) rf[i] <= 32'(i);
    else if (dp_wrReg && dp_rd != 4'd0) rf[dp_rd] <= dp_out_data;
  end
  assign dp_out_data = alu(dp_alu_control, rf[dp_rs], rf[dp_rt]);

  // Reference model: architectural registers updated per issued instruction.
  typedef struct packed { logic [31:0] data; logic [3:0] rd; logic err; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] arch [16];
  int unsigned exp_count;
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, acc_cyc = 0;
  bit          rand_bp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) arch[i] = 32'(i);
    exp_count = 0;
    exp_q.delete();
  endfunction

  function automatic void model_issue(input logic [15:0] ins);
    logic [3:0]  op, rd, rs, rt;
    logic [31:0] r;
    exp_t        e;
    op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    if (op[3] && TRAP) begin
      e.data = 32'd0; e.rd = rd; e.err = 1'b1;
    end else begin
      r = alu(op, arch[rs], arch[rt]);
      e.data = r; e.rd = rd; e.err = 1'b0;
      if (rd != 4'd0) arch[rd] = r;
      exp_count++;
    end
    exp_q.push_back(e);
  endfunction

  // Offer an instruction; returns 1ns after the accept edge (cycle 0).
  task automatic issue(input logic [15:0] ins);
    int t = 0;
    @(negedge clk);
    instr = ins; instr_valid = 1'b1;
    while (!instr_ready && t < 60) begin @(negedge clk); t++; end
    if (!instr_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      instr_valid = 1'b0;
    end else begin
      model_issue(ins);
      acc_cyc = cyc;
      @(posedge clk); #1;
      instr_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin @(negedge clk); t++; end
    chk("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: scoreboard pops on each response handshake plus protocol invariants.
  logic wr_prev = 0, vld_prev = 0, rdy_prev = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      chk("wr_in_reset", dp_wrReg, 0);
    end else begin
      chk("wr_single_cycle", dp_wrReg && wr_prev, 0);
      chk("ready_while_busy", instr_ready && busy, 0);
      if (vld_prev && !rdy_prev) chk("resp_valid_hold", resp_valid, 1);
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("resp_data", resp_data, e.data);
          chk("resp_rd", resp_rd, e.rd);
          chk("resp_err", resp_err, e.err);
        end
      end
    end
    wr_prev  <= dp_wrReg;
    vld_prev <= resp_valid && !reset;
    rdy_prev <= resp_ready;
  end

  // Random backpressure on the response channel.
  always @(posedge clk) if (rand_bp) begin #1; resp_ready = ($urandom_range(0, 3) != 0); end

  initial begin
    int a1, t;
    logic [3:0] op;
    model_reset();
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_instr_ready", instr_ready, 0);
    chk("rst_dp_rs", dp_rs, 0); chk("rst_dp_rt", dp_rt, 0);
    chk("rst_dp_rd", dp_rd, 0); chk("rst_dp_alu", dp_alu_control, 0);
    chk("rst_resp_valid", resp_valid, 0); chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_rd", resp_rd, 0); chk("rst_resp_err", resp_err, 0);
    chk("rst_busy", busy, 0); chk("rst_count", instr_count, 0);
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_ready_after", instr_ready, 1);

    // ADD R3=R1+R2 with cycle-exact latency
    issue(16'h0312);
    @(negedge clk);
    chk("add_c1_wr", dp_wrReg, 0); chk("add_c1_busy", busy, 1);
    chk("add_c1_rs", dp_rs, 1); chk("add_c1_rt", dp_rt, 2); chk("add_c1_op", dp_alu_control, 0);
    @(negedge clk);
    chk("add_c2_wr", dp_wrReg, 1); chk("add_c2_rd", dp_rd, 3); chk("add_c2_valid", resp_valid, 0);
    @(negedge clk);
    chk("add_c3_wr", dp_wrReg, 0); chk("add_c3_valid", resp_valid, 1);
    chk("add_count", instr_count, 1);
    drain();

    // Back-to-back SUB then SLL
    issue(16'h1453); a1 = acc_cyc;
    issue(16'h59D2);
    chk("b2b_interval", acc_cyc - a1, 4);
    drain();
    chk("b2b_count", instr_count, 2'd3);

    // Backpressure
    resp_ready = 1'b0;
    issue(16'h0A12);
    t = 0;
    @(negedge clk);
    while (!resp_valid && t < 20) begin @(negedge clk); t++; end
    chk("bp_valid_seen", resp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", resp_valid, 1);
      chk("bp_ready", instr_ready, 0);
      if (exp_q.size() > 0) chk("bp_data", resp_data, exp_q[0].data);
      @(negedge clk);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_busy", busy, 0); chk("bp_idle_ready", instr_ready, 1);
    drain();

    // Illegal opcode; hold the response so cycle 3 is comparable in both builds
    resp_ready = 1'b0;
    issue(16'h8312);
    @(negedge clk);
    chk("ill_c1_wr", dp_wrReg, 0);
    @(negedge clk);
    chk("ill_c2_wr", dp_wrReg, !TRAP); chk("ill_c2_valid", resp_valid, TRAP);
    @(negedge clk);
    chk("ill_c3_wr", dp_wrReg, 0); chk("ill_c3_valid", resp_valid, 1);
    chk("ill_count", instr_count, 16'(exp_count));
    @(posedge clk); #1 resp_ready = 1'b1;
    drain();

    // R0 write attempt then read of R0
    issue(16'h0FFF);
    drain();
    issue(16'h0201);
    drain();
    chk("r0_count", instr_count, 16'(exp_count));

    // Reset during DECODE
    issue(16'h0312);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("mid_ready", instr_ready, 1); chk("mid_count", instr_count, 0);
    chk("mid_dp_rd", dp_rd, 0);
    for (int i = 0; i < 5; i++) begin
      chk("mid_no_wr", dp_wrReg, 0); chk("mid_no_valid", resp_valid, 0);
      @(negedge clk);
    end

    // Randomized stream with random backpressure
    rand_bp = 1;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 9));
      if (op > 4'd7) op = 4'(8 + $urandom_range(0, 7));
      issue({op, 12'($urandom)});
    end
    drain();
    rand_bp = 0;
    @(posedge clk); #2 resp_ready = 1'b1;
    drain();
    chk("final_count", instr_count, 16'(exp_count));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
